// File: rtl/mem_bus_if_pkg.sv
// Shared definitions for the memory-stage bus interface.
//   - be_op size encodings (BE_WORD / BE_BYTE / BE_HALF; 2'd3 is handled as word)
//   - FSM state encodings (IDLE / REQ / DONE)
//   - store-side helpers: byte-enable generation and lane replication
package mem_bus_if_pkg;

    localparam logic [1:0] BE_WORD = 2'd0;
    localparam logic [1:0] BE_BYTE = 2'd1;
    localparam logic [1:0] BE_HALF = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte enables for a store of the given size at byte offset a.
    function automatic logic [3:0] store_be(input logic [1:0] be_op, input logic [1:0] a);
        case (be_op)
            BE_BYTE: store_be = 4'b0001 << a;
            BE_HALF: store_be = a[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Replicate right-justified store data across every lane it may land in.
    function automatic logic [31:0] store_lanes(input logic [1:0] be_op, input logic [31:0] wd);
        case (be_op)
            BE_BYTE: store_lanes = {4{wd[7:0]}};
            BE_HALF: store_lanes = {2{wd[15:0]}};
            default: store_lanes = wd;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_if_if.sv
// Data-memory bus bundle: request/ack handshake plus address, enables and data.
//   master: drives bus_req, bus_we, bus_addr, bus_be, bus_wdata; samples bus_ack, bus_rdata
//   slave : the memory side of the same signals
interface mem_bus_if_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/mem_bus_if_load_ext.sv
// Load lane select and extension (purely combinational, reusable in the W stage).
//   rdata         : full memory word
//   lane          : byte offset of the access
//   be_op         : access size (byte / half / word, 3 treated as word)
//   load_unsigned : 1 = zero-extend, 0 = sign-extend
//   result        : right-justified, extended load value
module mem_bus_if_load_ext
    import mem_bus_if_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  be_op,
    input  logic        load_unsigned,
    output logic [31:0] result
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_s = rdata[{lane, 3'b000} +: 8];
        half_s = lane[1] ? rdata[31:16] : rdata[15:0];
        case (be_op)
            BE_BYTE: result = load_unsigned ? {24'd0, byte_s} : 32'(byte_s);
            BE_HALF: result = load_unsigned ? {16'd0, half_s} : 32'(half_s);
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_bus_if.sv
// Memory-stage bus interface.
// Turns the M-stage load/store request into a req/ack transaction on the data
// memory bus, holds the pipeline in stall until the access completes, and
// returns the aligned/extended load result for the W stage.
//   clk, rst_n          : clock, asynchronous active-low reset
//   mem_write, mem_read : store / load request (write wins if both set)
//   be_op, load_unsigned: access size and load extension
//   addr, wdata         : byte address and right-justified store data
//   bus                 : memory bus (master side)
//   stall               : pipeline freeze
//   load_data/load_valid: load result and its one-cycle strobe
//   align_exc           : misaligned request seen in IDLE (combinational)
//   bus_err             : one-cycle pulse when an access times out
module mem_bus_if
    import mem_bus_if_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_write,
    input  logic         mem_read,
    input  logic [1:0]   be_op,
    input  logic         load_unsigned,
    input  logic [31:0]  addr,
    input  logic [31:0]  wdata,
    mem_bus_if_if.master bus,
    output logic         stall,
    output logic [31:0]  load_data,
    output logic         load_valid,
    output logic         align_exc,
    output logic         bus_err
);

    state_t          state_q, state_d;
    logic            is_word, is_half, misaligned, req_any, access;
    logic            accept, ack_hit, tmo;
    logic [TO_W-1:0] to_cnt;

    logic            req_p1, we_p1;
    logic [31:0]     addr_p1, wdata_p1;
    logic [3:0]      be_p1;
    logic [1:0]      lane_p1, be_op_p1;
    logic            unsigned_p1;
    logic [31:0]     ext_data;

    // ---- M stage: request decode (combinational) ----
    assign is_word    = (be_op == BE_WORD) || (be_op == 2'd3);
    assign is_half    = (be_op == BE_HALF);
    assign misaligned = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
    assign req_any    = mem_write | mem_read;
    assign access     = req_any & ~misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        align_exc = 1'b0;
        accept    = 1'b0;
        ack_hit   = 1'b0;
        tmo       = 1'b0;
        case (state_q)
            IDLE: begin
                stall     = access;
                align_exc = req_any & misaligned;
                if (access) begin
                    accept  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus.bus_ack) begin
                    ack_hit = 1'b1;
                    state_d = DONE;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    tmo     = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- bus stage: latched request, held stable for the whole of REQ ----
    // bus_we doubles as the "this was a store" flag when deciding load_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_p1      <= 1'b0;
            we_p1       <= 1'b0;
            addr_p1     <= '0;
            be_p1       <= '0;
            wdata_p1    <= '0;
            lane_p1     <= '0;
            be_op_p1    <= '0;
            unsigned_p1 <= 1'b0;
            to_cnt      <= '0;
            load_data   <= '0;
            load_valid  <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            bus_err    <= 1'b0;
            if (accept) begin
                req_p1      <= 1'b1;
                we_p1       <= mem_write;
                addr_p1     <= {addr[31:2], 2'b00};
                be_p1       <= mem_write ? store_be(be_op, addr[1:0]) : 4'b1111;
                wdata_p1    <= store_lanes(be_op, wdata);
                lane_p1     <= addr[1:0];
                be_op_p1    <= be_op;
                unsigned_p1 <= load_unsigned;
                to_cnt      <= '0;
            end else if (ack_hit) begin
                req_p1     <= 1'b0;
                load_data  <= ext_data;
                load_valid <= ~we_p1;
            end else if (tmo) begin
                req_p1     <= 1'b0;
                load_data  <= '0;
                load_valid <= ~we_p1;
                bus_err    <= 1'b1;
            end else if (state_q == REQ) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign bus.bus_req   = req_p1;
    assign bus.bus_we    = we_p1;
    assign bus.bus_addr  = addr_p1;
    assign bus.bus_be    = be_p1;
    assign bus.bus_wdata = wdata_p1;

    // ---- W-side: lane select / extend on the returning word ----
    mem_bus_if_load_ext u_load_ext (
        .rdata         (bus.bus_rdata),
        .lane          (lane_p1),
        .be_op         (be_op_p1),
        .load_unsigned (unsigned_p1),
        .result        (ext_data)
    );

endmodule

// File: tb/tb_mem_bus_if.sv
module tb_mem_bus_if;
    import mem_bus_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_write, mem_read, load_unsigned;
    logic [1:0]  be_op;
    logic [31:0] addr, wdata;
    logic        stall, load_valid, align_exc, bus_err;
    logic [31:0] load_data;

    mem_bus_if_if bus_i ();

    mem_bus_if #(.TIMEOUT(4), .TO_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_write     (mem_write),
        .mem_read      (mem_read),
        .be_op         (be_op),
        .load_unsigned (load_unsigned),
        .addr          (addr),
        .wdata         (wdata),
        .bus           (bus_i),
        .stall         (stall),
        .load_data     (load_data),
        .load_valid    (load_valid),
        .align_exc     (align_exc),
        .bus_err       (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    bus_t        exp_bus[$];
    logic [31:0] exp_load[$];
    logic [31:0] exp_err[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a transaction.
    logic req_prev = 1'b0;
    bus_t snap;

    always @(negedge clk) begin
        if (bus_i.bus_req && !req_prev) begin
            if (exp_bus.size() == 0) begin
                check("unexpected_bus_req", 32'(bus_i.bus_req), 32'd0);
            end else begin
                snap = exp_bus.pop_front();
                check("bus_we",    32'(bus_i.bus_we), 32'(snap.we));
                check("bus_addr",  bus_i.bus_addr,    snap.addr);
                check("bus_be",    32'(bus_i.bus_be), 32'(snap.be));
                check("bus_wdata", bus_i.bus_wdata,   snap.wdata);
            end
        end else if (bus_i.bus_req && req_prev) begin
            check("hold_addr",  bus_i.bus_addr,    snap.addr);
            check("hold_be",    32'(bus_i.bus_be), 32'(snap.be));
            check("hold_wdata", bus_i.bus_wdata,   snap.wdata);
        end
        if (load_valid) begin
            if (exp_load.size() == 0) check("unexpected_load_valid", 32'(load_valid), 32'd0);
            else check("load_data", load_data, exp_load.pop_front());
        end
        if (bus_err) begin
            if (exp_err.size() == 0) check("unexpected_bus_err", 32'(bus_err), 32'd0);
            else check("bus_err_addr", bus_i.bus_addr, exp_err.pop_front());
        end
        req_prev <= bus_i.bus_req;
    end

    task automatic idle_inputs();
        mem_write = 1'b0; mem_read = 1'b0; be_op = BE_WORD; load_unsigned = 1'b0;
        addr = '0; wdata = '0; bus_i.bus_ack = 1'b0; bus_i.bus_rdata = 32'hDEAD_BEEF;
    endtask

    // Starts at posedge+1 of the IDLE cycle; returns at posedge+1 after DONE.
    // ack_k < 1 means no ack is ever given.
    task automatic access(input string nm, input logic w, input logic r, input logic [1:0] op,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int ack_k, input int exp_stall);
        int  st;
        bit  done;
        st = 0; done = 1'b0;
        mem_write = w; mem_read = r; be_op = op; load_unsigned = uns; addr = a; wdata = wd;
        for (int cyc = 0; cyc < 40; cyc++) begin
            bus_i.bus_ack   = (ack_k >= 1) && (cyc == ack_k);
            bus_i.bus_rdata = (cyc == ack_k) ? rd : 32'hDEAD_BEEF;
            @(negedge clk);
            if (cyc == 0) check({nm, "_align_exc"}, 32'(align_exc), 32'd0);
            if (stall) st++;
            else begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({nm, "_done_reached"}, 32'(done), 32'd1);
        check({nm, "_stall_cycles"}, 32'(st), 32'(exp_stall));
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic misaligned_case(input string nm, input logic w, input logic [1:0] op,
                                   input logic [31:0] a);
        mem_write = w; mem_read = ~w; be_op = op; addr = a; wdata = 32'h0000_0001;
        @(negedge clk);
        check({nm, "_align_exc"}, 32'(align_exc), 32'd1);
        check({nm, "_stall"},     32'(stall), 32'd0);
        check({nm, "_bus_req"},   32'(bus_i.bus_req), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check({nm, "_bus_req_later"}, 32'(bus_i.bus_req), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lv_seen;
        rst_n = 1'b0;
        idle_inputs();
        #12;
        check("rst_bus_req",    32'(bus_i.bus_req), 32'd0);
        check("rst_bus_we",     32'(bus_i.bus_we), 32'd0);
        check("rst_bus_be",     32'(bus_i.bus_be), 32'd0);
        check("rst_bus_addr",   bus_i.bus_addr, 32'd0);
        check("rst_bus_wdata",  bus_i.bus_wdata, 32'd0);
        check("rst_load_data",  load_data, 32'd0);
        check("rst_load_valid", 32'(load_valid), 32'd0);
        check("rst_bus_err",    32'(bus_err), 32'd0);
        check("rst_stall",      32'(stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // sb at 0x1003, ack in the second REQ cycle
        exp_bus.push_back('{1'b1, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5});
        access("sb", 1, 0, BE_BYTE, 0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 2, 3);

        // lb / lbu from lane 2
        exp_bus.push_back('{1'b0, 32'h0000_2000, 4'b1111, 32'h0});
        exp_load.push_back(32'hFFFF_FFF0);
        access("lb", 0, 1, BE_BYTE, 0, 32'h0000_2002, 32'h0, 32'h12F0_5634, 1, 2);
        exp_bus.push_back('{1'b0, 32'h0000_2000, 4'b1111, 32'h0});
        exp_load.push_back(32'h0000_00F0);
        access("lbu", 0, 1, BE_BYTE, 1, 32'h0000_2002, 32'h0, 32'h12F0_5634, 1, 2);

        // lh upper half (negative), lhu lower half
        exp_bus.push_back('{1'b0, 32'h0000_2000, 4'b1111, 32'h0});
        exp_load.push_back(32'hFFFF_8001);
        access("lh", 0, 1, BE_HALF, 0, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 3, 4);
        exp_bus.push_back('{1'b0, 32'h0000_2000, 4'b1111, 32'h0});
        exp_load.push_back(32'h0000_7FFF);
        access("lhu", 0, 1, BE_HALF, 1, 32'h0000_2000, 32'h0, 32'h8001_7FFF, 1, 2);

        // lb lane 0 positive, lw via reserved size code 3
        exp_bus.push_back('{1'b0, 32'h0000_7000, 4'b1111, 32'h0});
        exp_load.push_back(32'h0000_007F);
        access("lb0", 0, 1, BE_BYTE, 0, 32'h0000_7000, 32'h0, 32'hFFFF_FF7F, 1, 2);
        exp_bus.push_back('{1'b0, 32'h0000_7004, 4'b1111, 32'h0});
        exp_load.push_back(32'hA5A5_0001);
        access("lw_op3", 0, 1, 2'd3, 0, 32'h0000_7004, 32'h0, 32'hA5A5_0001, 1, 2);

        // sh upper half
        exp_bus.push_back('{1'b1, 32'h0000_1000, 4'b1100, 32'hBEEF_BEEF});
        access("sh", 1, 0, BE_HALF, 0, 32'h0000_1002, 32'h1234_BEEF, 32'h0, 1, 2);

        // write and read together: write wins, no load result
        exp_bus.push_back('{1'b1, 32'h0000_6000, 4'b1111, 32'h0102_0304});
        access("wr_rd", 1, 1, BE_WORD, 0, 32'h0000_6000, 32'h0102_0304, 32'h0, 1, 2);

        // misaligned requests
        misaligned_case("lw_mis", 0, BE_WORD, 32'h0000_2001);
        misaligned_case("sh_mis", 1, BE_HALF, 32'h0000_1003);

        // timeout: 4 REQ cycles without ack
        exp_bus.push_back('{1'b0, 32'h0000_3000, 4'b1111, 32'h0});
        exp_load.push_back(32'h0);
        exp_err.push_back(32'h0000_3000);
        access("lw_to", 0, 1, BE_WORD, 0, 32'h0000_3000, 32'h0, 32'h0, -1, 5);
        check("to_bus_req_after", 32'(bus_i.bus_req), 32'd0);
        check("to_state_idle",    32'(dut.state_q), 32'(IDLE));

        // back-to-back sw then lw, ack in first REQ cycle
        exp_bus.push_back('{1'b1, 32'h0000_5004, 4'b1111, 32'hCAFE_F00D});
        access("b2b_sw", 1, 0, BE_WORD, 0, 32'h0000_5004, 32'hCAFE_F00D, 32'h0, 1, 2);
        exp_bus.push_back('{1'b0, 32'h0000_5004, 4'b1111, 32'hCAFE_F00D});
        exp_load.push_back(32'h1122_3344);
        access("b2b_lw", 0, 1, BE_WORD, 0, 32'h0000_5004, 32'hCAFE_F00D, 32'h1122_3344, 1, 2);

        // reset during REQ: request drops at once, later ack is ignored
        exp_bus.push_back('{1'b0, 32'h0000_4000, 4'b1111, 32'h0});
        mem_read = 1'b1; be_op = BE_WORD; addr = 32'h0000_4000;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rstreq_bus_req", 32'(bus_i.bus_req), 32'd0);
        check("rstreq_state",   32'(dut.state_q), 32'(IDLE));
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_i.bus_ack = 1'b1; bus_i.bus_rdata = 32'h5555_AAAA;
        lv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (load_valid || bus_i.bus_req) lv_seen++;
            @(posedge clk); #1;
            bus_i.bus_ack = 1'b0;
        end
        check("rstreq_no_activity", 32'(lv_seen), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("left_bus_exp",  32'(exp_bus.size()), 32'd0);
        check("left_load_exp", 32'(exp_load.size()), 32'd0);
        check("left_err_exp",  32'(exp_err.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
